vx_csr_bank_mw: RTL and testbench
=================================

// Module: vx_csr_bank_mw
// PURPOSE
//  Multi-warp CSR bank for a Vortex core: per-warp FP CSRs, per-warp scratch CSRs, writable cycle/instret counters.
//  Single request/response port with valid/ready handshake, registered response (latency 1).
//  Sits between the CSR unit and the commit/FPU/fetch stages.
//  Adds atomic read-old-value-on-write and error reporting on bad addresses.
// PARAMETERS
//  CORE_ID        0   core index used for GWID/GCID reads
//  NUM_WARPS      4   warps; NW_BITS = max(1,$clog2(NUM_WARPS))
//  NUM_THREADS    4   threads per warp; width of tmask slice and commit_size
//  CTR_WIDTH      48  cycle/instret width, 33..64
//  NUM_USER_CSRS  4   per-warp 32-bit scratch CSRs at 0x7C0.., 1..16
// PORTS
//  clk           in   1                      clock
//  reset_n       in   1                      synchronous, active-low reset
//  req_valid     in   1                      request valid
//  req_ready     out  1                      request accepted when valid&ready
//  req_write     in   1                      1=write (old value returned), 0=read
//  req_addr      in   12                     CSR address
//  req_wid       in   NW_BITS                issuing warp
//  req_data      in   32                     write data
//  rsp_valid     out  1                      response valid
//  rsp_ready     in   1                      response consumed when valid&ready
//  rsp_data      out  32                     read data / pre-write value
//  rsp_error     out  1                      illegal address or write to read-only CSR
//  fflags_valid  in   1                      FPU exception-flag accumulate
//  fflags_wid    in   NW_BITS                warp for fflags
//  fflags        in   5                      flags to OR in
//  frm_wid       in   NW_BITS                warp for rounding-mode lookup
//  frm_out       out  3                      frm of frm_wid (combinational)
//  tmask         in   NUM_WARPS*NUM_THREADS  thread masks, warp w at [w*NT +: NT]
//  busy          in   1                      core busy: enables cycle count
//  commit_valid  in   1                      commit event
//  commit_size   in   $clog2(NUM_THREADS+1)  instructions retired this cycle
// BEHAVIOUR
//  Map: 0x001 fflags, 0x002 frm, 0x003 fcsr (RW, per warp); 0x7C0+i scratch (RW, per warp);
//   0xB00/0xB80 mcycle lo/hi, 0xB02/0xB82 minstret lo/hi (RW, shared);
//   RO: 0xCC0 TMASK, 0xCC1 LWID, 0xCC2 GWID=CORE_ID*NUM_WARPS+wid, 0xCC3 GCID, 0xFC0 NT, 0xFC1 NW.
//  Output stage: one-entry register; FSM IDLE (rsp_valid=0) / HOLD (rsp_valid=1).
//   IDLE->HOLD on accept; HOLD->IDLE on rsp_ready & ~req_valid; HOLD->HOLD on rsp_ready & req_valid.
//   req_ready = ~rsp_valid | rsp_ready (full throughput, no comb path req_valid->req_ready).
//  Accepted request: read side samples state at accept cycle; write commits at same edge;
//   rsp_data = pre-write value; rsp_error=1 -> rsp_data=0, no state change.
//  rsp_data/rsp_error stable while rsp_valid & ~rsp_ready.
//  Counters wrap modulo 2^CTR_WIDTH; hi read = zero-extended bits [CTR_WIDTH-1:32];
//   lo write sets [31:0], hi write sets [CTR_WIDTH-1:32] (excess bits dropped).
//   Write same cycle as increment: write wins, increment dropped.
//  fflags: same-cycle CSR write and fflags_valid to same warp -> new = write_value | fflags (no lost flags).
//   fcsr write sets {frm,fflags}=req_data[7:0]; frm write sets req_data[2:0].
//  Reset (reset_n=0 at edge): rsp_valid=0, rsp_data=0, rsp_error=0, all counters/fcsr/scratch=0,
//   FSM->IDLE; pending response discarded. req_ready=0 while reset_n=0.
// CONFIGURATION
//  CSR_CTR_SNAPSHOT_EN defined: lo read of mcycle/minstret latches hi half into per-warp snapshot;
//   next hi read of same counter by same warp returns snapshot (atomic 64-bit pair); any other
//   request from that warp, or a write to that counter, clears it.
//  Undefined: hi reads return live value; no snapshot registers.
// TESTING
//  Reset then read 0xCC2 wid=2, CORE_ID=1, NW=4 -> rsp_data=6, rsp_error=0, one cycle after accept.
//  Write 0x003=0xE5 wid1 -> rsp 0x00; read 0x002 wid1 -> 7; frm_wid=1 -> frm_out=7; wid0 still 0.
//  fflags_valid wid0 flags=0x01 with CSR write 0x001=0x04 wid0 same cycle -> read 0x001 = 0x05.
//  Write 0xCC1 or read 0x123 -> rsp_error=1, rsp_data=0, no state change; next request unaffected.
//  Hold rsp_ready=0 3 cycles with req_valid=1 -> req_ready=0, rsp_data stable; release -> b2b accept.
//  Preload mcycle=0x0_FFFFFFFF, busy=1: read lo then hi -> with _EN hi=0 (snapshot); without -> hi=1.

Source files
------------

// File: rtl/vx_csr_bank_mw.sv
// vx_csr_bank_mw: multi-warp Vortex CSR bank with a registered valid/ready response port
// Ports: clk, reset_n (sync active-low); req_* request in, rsp_* one-entry registered response out;
//  fflags_* per-warp FPU flag accumulate; frm_wid -> frm_out rounding-mode lookup;
//  tmask, busy, commit_valid/commit_size core status feeding TMASK and the cycle/instret counters.
// Option: define CSR_CTR_SNAPSHOT_EN to latch a counter's hi half on its lo read so a lo/hi pair is atomic.
module vx_csr_bank_mw #(
  parameter int CORE_ID = 0,
  parameter int NUM_WARPS = 4,
  parameter int NUM_THREADS = 4,
  parameter int CTR_WIDTH = 48,
  parameter int NUM_USER_CSRS = 4,
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int CS_BITS = $clog2(NUM_THREADS + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [11:0]                      req_addr,
  input  logic [NW_BITS-1:0]               req_wid,
  input  logic [31:0]                      req_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_data,
  output logic                             rsp_error,
  input  logic                             fflags_valid,
  input  logic [NW_BITS-1:0]               fflags_wid,
  input  logic [4:0]                       fflags,
  input  logic [NW_BITS-1:0]               frm_wid,
  output logic [2:0]                       frm_out,
  input  logic [NUM_WARPS*NUM_THREADS-1:0] tmask,
  input  logic                             busy,
  input  logic                             commit_valid,
  input  logic [CS_BITS-1:0]               commit_size
);
  localparam int SU_BITS = (NUM_USER_CSRS > 1) ? $clog2(NUM_USER_CSRS) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state;
  logic [4:0] r_fflags [NUM_WARPS];
  logic [2:0] r_frm [NUM_WARPS];
  logic [31:0] r_scr [NUM_WARPS][NUM_USER_CSRS];
  logic [CTR_WIDTH-1:0] r_mcycle, r_minstret;
  logic [31:0] r_rsp_data;
  logic r_rsp_error;
  logic [63:0] w_mc64, w_mi64;
  logic [31:0] w_rd;
  logic w_legal, w_ro, w_err, w_acc, w_wr, w_is_scr, w_ffwr, w_frwr;
  logic [SU_BITS-1:0] w_sidx;
`ifdef CSR_CTR_SNAPSHOT_EN
  logic [1:0] r_snap_v [NUM_WARPS];
  logic [31:0] r_snap [NUM_WARPS][2];
  logic [1:0] w_lo_rd, w_ctr_wr;
`endif
  assign rsp_valid = (r_state == HOLD);
  assign rsp_data = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign req_ready = reset_n & (~rsp_valid | rsp_ready);
  assign w_acc = req_valid & req_ready;
  assign w_err = ~w_legal | (req_write & w_ro);
  assign w_wr = w_acc & req_write & ~w_err;
  assign w_mc64 = 64'(r_mcycle);
  assign w_mi64 = 64'(r_minstret);
  assign w_is_scr = (req_addr[11:4] == 8'h7C) && ({28'd0, req_addr[3:0]} < NUM_USER_CSRS);
  assign w_sidx = req_addr[SU_BITS-1:0];
  assign w_ffwr = w_wr && (req_addr == 12'h001 || req_addr == 12'h003);
  assign w_frwr = w_wr && (req_addr == 12'h002 || req_addr == 12'h003);
  assign frm_out = r_frm[frm_wid];
  always_comb begin
    w_rd = '0;
    w_legal = 1'b1;
    w_ro = 1'b0;
    case (req_addr)
      12'h001: w_rd = {27'd0, r_fflags[req_wid]};
      12'h002: w_rd = {29'd0, r_frm[req_wid]};
      12'h003: w_rd = {24'd0, r_frm[req_wid], r_fflags[req_wid]};
      12'hB00: w_rd = w_mc64[31:0];
      12'hB80: w_rd = w_mc64[63:32];
      12'hB02: w_rd = w_mi64[31:0];
      12'hB82: w_rd = w_mi64[63:32];
      12'hCC0: begin w_rd = 32'(tmask[req_wid*NUM_THREADS +: NUM_THREADS]); w_ro = 1'b1; end
      12'hCC1: begin w_rd = 32'(req_wid); w_ro = 1'b1; end
      12'hCC2: begin w_rd = 32'(CORE_ID * NUM_WARPS) + 32'(req_wid); w_ro = 1'b1; end
      12'hCC3: begin w_rd = 32'(CORE_ID); w_ro = 1'b1; end
      12'hFC0: begin w_rd = 32'(NUM_THREADS); w_ro = 1'b1; end
      12'hFC1: begin w_rd = 32'(NUM_WARPS); w_ro = 1'b1; end
      default: begin w_legal = w_is_scr; w_rd = w_is_scr ? r_scr[req_wid][w_sidx] : '0; end
    endcase
`ifdef CSR_CTR_SNAPSHOT_EN
    if (!req_write && req_addr == 12'hB80 && r_snap_v[req_wid][0]) w_rd = r_snap[req_wid][0];
    if (!req_write && req_addr == 12'hB82 && r_snap_v[req_wid][1]) w_rd = r_snap[req_wid][1];
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rsp_data <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_acc) begin
      r_state <= HOLD;
      r_rsp_data <= w_err ? '0 : w_rd;
      r_rsp_error <= w_err;
    end else if (rsp_ready) r_state <= IDLE;
  end
  // Counter writes take priority over the same-cycle increment; lo/hi writes keep the other half.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mcycle <= '0;
      r_minstret <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_fflags[w] <= '0;
        r_frm[w] <= '0;
        for (int s = 0; s < NUM_USER_CSRS; s++) r_scr[w][s] <= '0;
      end
    end else begin
      r_mcycle <= (w_wr && req_addr == 12'hB00) ? CTR_WIDTH'({w_mc64[63:32], req_data})
                : (w_wr && req_addr == 12'hB80) ? CTR_WIDTH'({req_data, w_mc64[31:0]})
                : r_mcycle + CTR_WIDTH'(busy);
      r_minstret <= (w_wr && req_addr == 12'hB02) ? CTR_WIDTH'({w_mi64[63:32], req_data})
                  : (w_wr && req_addr == 12'hB82) ? CTR_WIDTH'({req_data, w_mi64[31:0]})
                  : r_minstret + (commit_valid ? CTR_WIDTH'(commit_size) : '0);
      // FPU flags are ORed on top of a same-cycle CSR write so no exception is lost.
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_fflags[w] <= ((w_ffwr && req_wid == NW_BITS'(w)) ? req_data[4:0] : r_fflags[w])
                     | ((fflags_valid && fflags_wid == NW_BITS'(w)) ? fflags : 5'd0);
        r_frm[w] <= (w_frwr && req_wid == NW_BITS'(w)) ? (req_addr[0] ? req_data[7:5] : req_data[2:0]) : r_frm[w];
      end
      if (w_wr && w_is_scr) r_scr[req_wid][w_sidx] <= req_data;
    end
  end
`ifdef CSR_CTR_SNAPSHOT_EN
  // Bit 0 tracks mcycle, bit 1 minstret; any request from the warp re-arms or clears its snapshots.
  assign w_lo_rd = {2{w_acc & ~req_write}} & {req_addr == 12'hB02, req_addr == 12'hB00};
  assign w_ctr_wr = {2{w_wr}} & {req_addr == 12'hB02 || req_addr == 12'hB82, req_addr == 12'hB00 || req_addr == 12'hB80};
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!reset_n) r_snap_v[w] <= '0;
      else if (w_acc && req_wid == NW_BITS'(w)) r_snap_v[w] <= w_lo_rd;
      else r_snap_v[w] <= r_snap_v[w] & ~w_ctr_wr;
      if (w_lo_rd[0] && req_wid == NW_BITS'(w)) r_snap[w][0] <= w_mc64[63:32];
      if (w_lo_rd[1] && req_wid == NW_BITS'(w)) r_snap[w][1] <= w_mi64[63:32];
    end
  end
`endif
endmodule

// File: tb/tb_vx_csr_bank_mw.sv
// tb_vx_csr_bank_mw: scoreboard bench for vx_csr_bank_mw (CORE_ID=1, 4 warps x 4 threads, 48-bit counters)
module tb_vx_csr_bank_mw;
  logic clk = 0, reset_n = 0;
  logic req_valid = 0, req_write = 0, req_ready;
  logic [11:0] req_addr = 0;
  logic [1:0] req_wid = 0, fflags_wid = 0, frm_wid = 0;
  logic [31:0] req_data = 0, rsp_data;
  logic rsp_valid, rsp_error, rsp_ready = 1;
  logic fflags_valid = 0, busy = 0, commit_valid = 0;
  logic [4:0] fflags = 0;
  logic [2:0] frm_out, commit_size = 0;
  logic [15:0] tmask = 16'hA5C3;
  typedef struct {logic [31:0] d; logic e; string t;} exp_t;
  exp_t q[$];
  exp_t m_x;
  int n_chk = 0, n_err = 0;
  bit mon_en = 1;
  always #5 clk = ~clk;
  vx_csr_bank_mw #(.CORE_ID(1), .NUM_WARPS(4), .NUM_THREADS(4), .CTR_WIDTH(48), .NUM_USER_CSRS(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wid(req_wid), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error), .fflags_valid(fflags_valid),
    .fflags_wid(fflags_wid), .fflags(fflags), .frm_wid(frm_wid), .frm_out(frm_out), .tmask(tmask),
    .busy(busy), .commit_valid(commit_valid), .commit_size(commit_size));
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", t, got, exp);
    end
  endtask
  // Leaves req_valid high so a following send() is back-to-back; call idle() otherwise.
  task automatic send(input logic wr, input logic [11:0] a, input logic [1:0] w, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee, input string t);
    bit ok = 0;
    req_valid = 1; req_write = wr; req_addr = a; req_wid = w; req_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
    end
    chk({t, "_accept"}, {31'd0, ok}, 1);
    if (ok) q.push_back('{ed, ee, t});
  endtask
  task automatic idle();
    req_valid = 0;
    @(posedge clk); #1;
  endtask
  task automatic drain();
    req_valid = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin @(posedge clk); #1; end
    chk("drain", q.size(), 0);
  endtask
  always @(negedge clk) if (mon_en) begin
    if (q.size() == 0) chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
    else begin
      chk({q[0].t, "_valid"}, {31'd0, rsp_valid}, 1);
      if (rsp_valid && rsp_ready) begin
        m_x = q.pop_front();
        chk(m_x.t, rsp_data, m_x.d);
        chk({m_x.t, "_err"}, {31'd0, rsp_error}, {31'd0, m_x.e});
      end
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_frm", {29'd0, frm_out}, 0);
    @(posedge clk); #1;
    reset_n = 1;
    send(0, 12'hCC2, 2, 0, 6, 0, "gwid");
    send(1, 12'h003, 1, 32'hE5, 0, 0, "fcsr_wr");
    send(0, 12'h002, 1, 0, 7, 0, "frm_rd");
    frm_wid = 1;
    chk("frm_out_w1", {29'd0, frm_out}, 7);
    frm_wid = 0;
    chk("frm_out_w0", {29'd0, frm_out}, 0);
    send(0, 12'h001, 1, 0, 5, 0, "fflags_rd");
    fflags_valid = 1; fflags_wid = 0; fflags = 5'h01;
    send(1, 12'h001, 0, 32'h04, 0, 0, "ff_wr");
    fflags_valid = 0;
    send(0, 12'h001, 0, 0, 5, 0, "ff_merge");
    fflags_valid = 1; fflags_wid = 2; fflags = 5'h10;
    idle();
    fflags_valid = 0;
    send(0, 12'h003, 2, 0, 32'h10, 0, "ff_acc");
    send(1, 12'hCC1, 0, 5, 0, 1, "ro_wr");
    send(0, 12'h123, 0, 0, 0, 1, "bad_addr");
    send(0, 12'hCC1, 3, 0, 3, 0, "lwid");
    send(1, 12'h7C4, 0, 7, 0, 1, "scr_oob");
    send(0, 12'h003, 1, 0, 32'hE5, 0, "fcsr_keep");
    send(0, 12'hCC0, 1, 0, 32'hC, 0, "tmask");
    send(0, 12'hCC3, 0, 0, 1, 0, "gcid");
    send(0, 12'hFC0, 0, 0, 4, 0, "nt");
    send(0, 12'hFC1, 0, 0, 4, 0, "nw");
    send(1, 12'h7C3, 2, 32'hDEADBEEF, 0, 0, "scr_wr");
    send(0, 12'h7C3, 2, 0, 32'hDEADBEEF, 0, "scr_rd");
    send(0, 12'h7C3, 1, 0, 0, 0, "scr_other");
    send(1, 12'h7C3, 2, 1, 32'hDEADBEEF, 0, "scr_old");
    send(1, 12'hB82, 0, 32'hFFFF1234, 0, 0, "mi_hi_wr");
    send(0, 12'hB82, 0, 0, 32'h1234, 0, "mi_hi_rd");
    send(1, 12'hB02, 0, 32'hFFFFFFFE, 0, 0, "mi_lo_wr");
    commit_valid = 1; commit_size = 3;
    idle();
    commit_valid = 0;
    send(0, 12'hB02, 0, 0, 1, 0, "mi_lo_inc");
    send(0, 12'hB82, 0, 0, 32'h1235, 0, "mi_hi_inc");
    commit_valid = 1; commit_size = 2;
    send(1, 12'hB02, 0, 32'h10, 1, 0, "mi_wr_win");
    commit_valid = 0;
    send(0, 12'hB02, 0, 0, 32'h10, 0, "mi_after");
    send(1, 12'hB00, 0, 32'hFFFFFFFF, 0, 0, "mc_lo_wr");
    idle();
    busy = 1;
    send(0, 12'hB00, 0, 0, 32'hFFFFFFFF, 0, "mc_lo_rd");
    busy = 0;
`ifdef CSR_CTR_SNAPSHOT_EN
    send(0, 12'hB80, 0, 0, 0, 0, "mc_hi_snap");
`else
    send(0, 12'hB80, 0, 0, 1, 0, "mc_hi_live");
`endif
    send(0, 12'hB80, 0, 0, 1, 0, "mc_hi_again");
    send(1, 12'hB80, 0, 32'hFFFF, 1, 0, "mc_hi_wr");
    send(1, 12'hB00, 0, 32'hFFFFFFFF, 0, 0, "mc_lo_wr2");
    idle();
    busy = 1;
    send(0, 12'hB00, 0, 0, 32'hFFFFFFFF, 0, "mc_lo_rd2");
    busy = 0;
`ifdef CSR_CTR_SNAPSHOT_EN
    send(0, 12'hB80, 0, 0, 32'hFFFF, 0, "mc_wrap_snap");
`else
    send(0, 12'hB80, 0, 0, 0, 0, "mc_wrap_hi");
`endif
    send(0, 12'hB00, 0, 0, 0, 0, "mc_wrap_lo");
    drain();
    rsp_ready = 0;
    send(0, 12'hFC1, 0, 0, 4, 0, "hold_a");
    req_addr = 12'hCC2; req_wid = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req_ready", {31'd0, req_ready}, 0);
      chk("hold_data", rsp_data, 4);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    send(0, 12'hCC2, 3, 0, 7, 0, "hold_b");
    drain();
    mon_en = 0;
    rsp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = 12'hCC3; req_wid = 0;
    @(posedge clk); #1;
    req_valid = 0;
    chk("pre_rst_valid", {31'd0, rsp_valid}, 1);
    reset_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_data", rsp_data, 0);
    chk("mid_rst_ready", {31'd0, req_ready}, 0);
    reset_n = 1; rsp_ready = 1; mon_en = 1;
    send(0, 12'h003, 1, 0, 0, 0, "rst_fcsr");
    send(0, 12'h7C3, 2, 0, 0, 0, "rst_scr");
    send(0, 12'hB02, 0, 0, 0, 0, "rst_ctr");
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
